// File: rtl/shifted_a_mult_add.sv
// -----------------------------------------------------------------------------
// shifted_a_mult_add
//
// Pipelined arithmetic slice for FIR/accumulator datapaths:
//   z = ((a << acc_fir) + b * COEFF) mod 2^Z_W, all unsigned.
// Bits shifted past bit Z_W-1 are discarded. A shift of Z_W or more gives a
// zero shift term, and the carry out of the final add is dropped.
//
// Optional build macro:
//   SHIFTED_MULT_INREG_EN  - adds an input register stage (latency 2).
//                            Without it, only the output is registered
//                            (latency 1). Throughput is one operand set per
//                            cycle in both builds.
//
// Ports:
//   clk       in   1     rising-edge clock
//   reset_n   in   1     asynchronous active-low reset
//   in_valid  in   1     a/b/acc_fir qualify this cycle
//   a         in   A_W   unsigned operand to be shifted
//   b         in   B_W   unsigned operand to be multiplied by COEFF
//   acc_fir   in   SH_W  left-shift amount for a (full range, not reduced)
//   out_valid out  1     z_out holds a new result
//   z_out     out  Z_W   unsigned result; holds its value when no new result
// -----------------------------------------------------------------------------
module shifted_a_mult_add #(
  parameter int unsigned A_W   = 20,
  parameter int unsigned B_W   = 18,
  parameter int unsigned SH_W  = 6,
  parameter int unsigned Z_W   = 38,
  parameter int unsigned COEFF = 4096
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic [A_W-1:0]  a,
  input  logic [B_W-1:0]  b,
  input  logic [SH_W-1:0] acc_fir,
  output logic            out_valid,
  output logic [Z_W-1:0]  z_out
);

  localparam logic [Z_W-1:0]  COEFF_Z   = Z_W'(COEFF);
  // Shift amounts at or above this value push every bit of a out of range.
  localparam logic [SH_W-1:0] SH_LIMIT  = SH_W'(Z_W);

  // Operands feeding the arithmetic: either the ports directly or their
  // registered copies, depending on the build.
  logic            op_valid;
  logic [A_W-1:0]  op_a;
  logic [B_W-1:0]  op_b;
  logic [SH_W-1:0] op_sh;

`ifdef SHIFTED_MULT_INREG_EN
  logic            in_valid_q, in_valid_d;
  logic [A_W-1:0]  a_q,        a_d;
  logic [B_W-1:0]  b_q,        b_d;
  logic [SH_W-1:0] acc_fir_q,  acc_fir_d;

  // Input stage captures unconditionally; in_valid travels with the data so
  // a non-valid cycle simply propagates as a bubble.
  always_comb begin
    in_valid_d = in_valid;
    a_d        = a;
    b_d        = b;
    acc_fir_d  = acc_fir;
  end

  // NOTE: every register, datapath included, is cleared by reset so that no
  // stale operand can surface as a result after reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      acc_fir_q  <= '0;
    end else begin
      in_valid_q <= in_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_fir_q  <= acc_fir_d;
    end
  end

  assign op_valid = in_valid_q;
  assign op_a     = a_q;
  assign op_b     = b_q;
  assign op_sh    = acc_fir_q;
`else
  assign op_valid = in_valid;
  assign op_a     = a;
  assign op_b     = b;
  assign op_sh    = acc_fir;
`endif

  // ---------------------------------------------------------------------------
  // Arithmetic, evaluated entirely in Z_W bits
  // ---------------------------------------------------------------------------
  logic [Z_W-1:0] a_ext;
  logic [Z_W-1:0] b_ext;
  logic [Z_W-1:0] sh_term;
  logic [Z_W-1:0] prod_term;
  logic [Z_W-1:0] sum;

  // NOTE: each combinational output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    a_ext     = Z_W'(op_a);
    b_ext     = Z_W'(op_b);
    sh_term   = '0;
    // Explicit range check keeps the large-shift behaviour obvious instead
    // of relying on shift-operator semantics for oversize amounts.
    if (op_sh < SH_LIMIT) begin
      sh_term = a_ext << op_sh;
    end
    prod_term = b_ext * COEFF_Z;
    // Z_W-bit add: the carry out is deliberately dropped (modular result).
    sum       = sh_term + prod_term;
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic           out_valid_q, out_valid_d;
  logic [Z_W-1:0] z_q,         z_d;

  always_comb begin
    out_valid_d = op_valid;
    z_d         = z_q;
    if (op_valid) begin
      z_d = sum;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      z_q         <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
    end
  end

  assign out_valid = out_valid_q;
  assign z_out     = z_q;

endmodule

// File: tb/tb_shifted_a_mult_add.sv
// -----------------------------------------------------------------------------
// tb_shifted_a_mult_add
//
// Self-checking bench for shifted_a_mult_add. Directed cases with known
// results, a mid-run asynchronous reset, then random traffic compared against
// a queue-based reference model. Build with SHIFTED_MULT_INREG_EN defined to
// exercise the two-cycle-latency variant.
// -----------------------------------------------------------------------------
module tb_shifted_a_mult_add;

`ifdef SHIFTED_MULT_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [19:0] a;
  logic [17:0] b;
  logic [5:0]  acc_fir;
  logic        out_valid;
  logic [37:0] z_out;

  int n_asserts = 0;
  int n_fail    = 0;

  shifted_a_mult_add dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .acc_fir   (acc_fir),
    .out_valid (out_valid),
    .z_out     (z_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue entry per clock edge, each carrying the
  // validity and mathematically computed result of the operands offered.
  typedef struct {
    bit          v;
    logic [37:0] z;
  } ent_t;

  ent_t        pipe_q[$];
  bit          exp_v;
  logic [37:0] exp_z;

  function automatic logic [37:0] ref_z(input logic [19:0] av,
                                        input logic [17:0] bv,
                                        input logic [5:0]  sv);
    logic [63:0] t;
    t = (64'(av) << sv) + 64'(bv) * 64'd4096;
    return t[37:0];
  endfunction

  task automatic model_reset();
    ent_t e;
    e.v = 1'b0;
    e.z = '0;
    pipe_q.delete();
    for (int i = 0; i < LAT - 1; i++) pipe_q.push_back(e);
    exp_v = 1'b0;
    exp_z = '0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
    n_asserts++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs (called just after a falling edge), advance
  // the model on the rising edge, and check outputs at the next falling edge.
  task automatic step(input string tag, input bit v, input logic [19:0] av,
                      input logic [17:0] bv, input logic [5:0] sv);
    ent_t e;
    ent_t head;
    in_valid = v;
    a        = av;
    b        = bv;
    acc_fir  = sv;
    @(posedge clk);
    e.v = v;
    e.z = ref_z(av, bv, sv);
    pipe_q.push_back(e);
    head  = pipe_q.pop_front();
    exp_v = head.v;
    if (head.v) exp_z = head.z;
    @(negedge clk);
    check({tag, "_valid"}, 64'(out_valid), 64'(exp_v));
    check({tag, "_z"},     64'(z_out),     64'(exp_z));
  endtask

  // One valid operand set followed by enough idle cycles to reach the output,
  // then a comparison against a hand-computed constant.
  task automatic directed(input string tag, input logic [19:0] av,
                          input logic [17:0] bv, input logic [5:0] sv,
                          input logic [37:0] want);
    step(tag, 1'b1, av, bv, sv);
    for (int i = 0; i < LAT - 1; i++) step(tag, 1'b0, '0, '0, '0);
    check({tag, "_const_z"},     64'(z_out),     64'(want));
    check({tag, "_const_valid"}, 64'(out_valid), 64'd1);
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    acc_fir  = '0;
    model_reset();

    // Power-up reset
    repeat (2) @(negedge clk);
    check("por_z",     64'(z_out),     64'd0);
    check("por_valid", 64'(out_valid), 64'd0);
    reset_n = 1'b1;

    // a=255, b=1, acc_fir=1 three times back to back -> 4606 every cycle
    for (int i = 0; i < 3 + LAT - 1; i++) begin
      step("b2b", i < 3, 20'd255, 18'd1, 6'd1);
      if (i >= LAT - 1) begin
        check("b2b_const_z",     64'(z_out),     64'd4606);
        check("b2b_const_valid", 64'(out_valid), 64'd1);
      end
    end

    // Mid-run asynchronous reset with in_valid held high
    in_valid = 1'b1;
    a        = 20'hABCDE;
    b        = 18'h12345;
    acc_fir  = 6'd3;
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_z",     64'(z_out),     64'd0);
    check("async_rst_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_held_z",     64'(z_out),     64'd0);
    check("rst_held_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step("post_rst_idle", 1'b0, 20'hFFFFF, 18'h3FFFF, 6'd5);
      check("post_rst_const_z", 64'(z_out), 64'd0);
    end

    // Boundary cases
    directed("max_sh63",  20'hFFFFF, 18'h3FFFF, 6'd63, 38'd1073737728);
    directed("wrap_zero", 20'hFFFFF, 18'd64,    6'd18, 38'd0);
    directed("wrap_b63",  20'hFFFFF, 18'd63,    6'd18, 38'd274877902848);
    directed("sh37",      20'd1,     18'd0,     6'd37, 38'd137438953472);
    directed("sh38",      20'd1,     18'd0,     6'd38, 38'd0);

    // Hold behaviour: idle cycles keep z_out, drop out_valid
    step("hold", 1'b0, 20'h5A5A5, 18'h2AAAA, 6'd7);
    check("hold_const_z", 64'(z_out), 64'd0);

    // Random traffic
    for (int i = 0; i < 1000; i++) begin
      step("rand", ($urandom_range(3) != 0),
           20'($urandom), 18'($urandom), 6'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule
